// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcodes, IR field positions and
// the sequencer state encoding.
package cpu_pkg;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  localparam int OPER_TYPE_HI = 31;
  localparam int OPER_TYPE_LO = 27;
  localparam int RDST_HI      = 26;
  localparam int RDST_LO      = 22;
  localparam int RSRC1_HI     = 21;
  localparam int RSRC1_LO     = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_HI     = 15;
  localparam int RSRC2_LO     = 11;
  localparam int ISRC_HI      = 15;
  localparam int ISRC_LO      = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_DECODE  = 3'd3;
  localparam logic [2:0] ST_EXEC    = 3'd4;
  localparam logic [2:0] ST_MULWAIT = 3'd5;
  localparam logic [2:0] ST_RETIRE  = 3'd6;
  localparam logic [2:0] ST_HALTED  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_FETCH   = ST_FETCH,
    S_LATCH   = ST_LATCH,
    S_DECODE  = ST_DECODE,
    S_EXEC    = ST_EXEC,
    S_MULWAIT = ST_MULWAIT,
    S_RETIRE  = ST_RETIRE,
    S_HALTED  = ST_HALTED
  } seq_state_t;

  function automatic logic [4:0] oper_type(input logic [31:0] instr);
    return instr[OPER_TYPE_HI:OPER_TYPE_LO];
  endfunction

  // Opcodes the datapath can execute; everything else either halts or is illegal.
  function automatic logic is_exec_op(input logic [4:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer: fetch/latch/decode/execute/retire FSM with mul wait
// states, run/step/halt control and a saturating retired-instruction counter.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic              exec_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  retired
);

  localparam int WCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  seq_state_t        state, state_nxt;
  logic              step_mode;
  logic [WCNT_W-1:0] wait_cnt;
  logic [4:0]        op;
  logic              is_mul;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign op        = oper_type(ir);
  assign is_mul    = (op == OP_MUL) && (MUL_LAT > 0);
  assign imem_addr = pc;
  assign busy      = (state != S_IDLE) && (state != S_HALTED);
  assign halted    = (state == S_HALTED);

  always_comb begin
    state_nxt  = state;
    imem_rd_en = 1'b0;
    exec_valid = 1'b0;
    case (state)
      S_IDLE:    if (run || step) state_nxt = S_FETCH;
      S_FETCH: begin
        imem_rd_en = 1'b1;
        state_nxt  = S_LATCH;
      end
      S_LATCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = is_exec_op(op) ? S_EXEC : S_HALTED;
      S_EXEC: begin
        exec_valid = 1'b1;
        state_nxt  = is_mul ? S_MULWAIT : S_RETIRE;
      end
      S_MULWAIT: if (wait_cnt == '0) state_nxt = S_RETIRE;
      S_RETIRE: begin
        if (halt_req)              state_nxt = S_HALTED;
        else if (step_mode || !run) state_nxt = S_IDLE;
        else                       state_nxt = S_FETCH;
      end
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      step_mode  <= 1'b0;
      wait_cnt   <= '0;
      pc         <= '0;
      ir         <= '0;
      retired    <= '0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:    if (run || step) step_mode <= step & ~run;
        S_LATCH:   ir <= imem_rdata;
        S_DECODE: begin
          // HALT counts as a retired instruction; an undefined opcode does not.
          if (op == OP_HALT)       retired    <= sat_inc(retired);
          else if (!is_exec_op(op)) illegal_op <= 1'b1;
        end
        S_EXEC:    if (is_mul) wait_cnt <= WCNT_W'(MUL_LAT - 1);
        S_MULWAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        S_RETIRE: begin
          pc      <= pc + 1'b1;
          retired <= sat_inc(retired);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: a default-parameter instance (A) and a tiny one
// (B: 2-bit PC, no mul wait, 2-bit retired counter), checked against a program model.
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;

  localparam int A_MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_run, a_step, a_halt, a_rd_en, a_exec, a_busy, a_halted, a_ill;
  logic [7:0]  a_addr, a_pc;
  logic [31:0] a_rdata, a_ir;
  logic [15:0] a_ret;
  logic [31:0] a_mem [256];

  logic        b_run, b_step, b_halt, b_rd_en, b_exec, b_busy, b_halted, b_ill;
  logic [1:0]  b_addr, b_pc, b_ret;
  logic [31:0] b_rdata, b_ir;
  logic [31:0] b_mem [4];

  cpu_seq_ctrl #(.ADDR_W(8), .MUL_LAT(A_MUL_LAT), .CNT_W(16)) dut_a (
    .clk(clk), .sys_rst_n(rst_n), .run(a_run), .step(a_step), .halt_req(a_halt),
    .imem_rd_en(a_rd_en), .imem_addr(a_addr), .imem_rdata(a_rdata), .ir(a_ir),
    .exec_valid(a_exec), .pc(a_pc), .busy(a_busy), .halted(a_halted),
    .illegal_op(a_ill), .retired(a_ret));

  cpu_seq_ctrl #(.ADDR_W(2), .MUL_LAT(0), .CNT_W(2)) dut_b (
    .clk(clk), .sys_rst_n(rst_n), .run(b_run), .step(b_step), .halt_req(b_halt),
    .imem_rd_en(b_rd_en), .imem_addr(b_addr), .imem_rdata(b_rdata), .ir(b_ir),
    .exec_valid(b_exec), .pc(b_pc), .busy(b_busy), .halted(b_halted),
    .illegal_op(b_ill), .retired(b_ret));

  always @(posedge clk) if (a_rd_en) a_rdata <= a_mem[a_addr];
  always @(posedge clk) if (b_rd_en) b_rdata <= b_mem[b_addr];

  int          cyc = 0;
  int          a_fetch_q[$], a_addr_q[$], a_exec_q[$];
  logic [31:0] a_ir_q[$];
  int          b_fetch_q[$], b_addr_q[$], b_exec_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (a_rd_en) begin a_fetch_q.push_back(cyc); a_addr_q.push_back(int'(a_addr)); end
    if (a_exec)  begin a_exec_q.push_back(cyc);  a_ir_q.push_back(a_ir); end
    if (b_rd_en) begin b_fetch_q.push_back(cyc); b_addr_q.push_back(int'(b_addr)); end
    if (b_exec)  b_exec_q.push_back(cyc);
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          m_pc, m_ret, m_exec;
  logic        m_ill;
  int          m_int_q[$];
  logic [31:0] m_ir_q[$];

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic imm,
                                      input logic [15:0] src);
    logic [31:0] w;
    w = '0;
    w[OPER_TYPE_HI:OPER_TYPE_LO] = op;
    w[RDST_HI:RDST_LO]           = rd;
    w[RSRC1_HI:RSRC1_LO]         = rs1;
    w[IMM_MODE_BIT]              = imm;
    if (imm) w[ISRC_HI:ISRC_LO] = src;
    else     w[RSRC2_HI:RSRC2_LO] = src[4:0];
    return w;
  endfunction

  function automatic logic [31:0] rnd_instr(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    r[OPER_TYPE_HI:OPER_TYPE_LO] = op;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    a_fetch_q.delete(); a_addr_q.delete(); a_exec_q.delete(); a_ir_q.delete();
    b_fetch_q.delete(); b_addr_q.delete(); b_exec_q.delete();
  endtask

  task automatic do_reset();
    a_run = 0; a_step = 0; a_halt = 0;
    b_run = 0; b_step = 0; b_halt = 0;
    rst_n = 0;
    for (int i = 0; i < 256; i++) a_mem[i] = enc(OP_HALT, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)   b_mem[i] = enc(OP_ADD, 5'(i), 1, 1, 16'(i));
    repeat (3) tick();
    rst_n = 1;
    tick();
    clear_q();
  endtask

  task automatic wait_stop(input bit use_b, input int budget, input string name);
    int n;
    n = 0;
    tick();
    while (((use_b ? b_busy : a_busy) === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, required idle or halted", name, budget);
    end
  endtask

  task automatic wait_exec(input int cnt, input int budget, input string name);
    int n;
    n = 0;
    while (a_exec_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: saw %0d exec strobes, required %0d", name, a_exec_q.size(), cnt);
    end
  endtask

  // Walks the program in a_mem from address 0 the way the ISA defines it.
  task automatic model_prog();
    logic [4:0] op;
    m_pc = 0; m_ret = 0; m_exec = 0; m_ill = 0;
    m_int_q.delete(); m_ir_q.delete();
    for (int k = 0; k < 256; k++) begin
      op = a_mem[m_pc][31:27];
      if (op <= 5'd4) begin
        m_ir_q.push_back(a_mem[m_pc]);
        m_int_q.push_back((op == 5'd4) ? 5 + A_MUL_LAT : 5);
        m_exec++;
        m_ret++;
        m_pc = (m_pc + 1) % 256;
      end else begin
        if (op == 5'd31) m_ret++;
        else             m_ill = 1;
        break;
      end
    end
  endtask

  task automatic check_a_reset_values(input string name);
    n_checks++;
    if ({a_rd_en, a_exec, a_busy, a_halted, a_ill} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s flags: got rd_en/exec/busy/halted/ill=%b required 00000", name,
               {a_rd_en, a_exec, a_busy, a_halted, a_ill});
    end
    n_checks++;
    if (a_pc !== 8'd0 || a_ir !== 32'd0 || a_ret !== 16'd0) begin
      n_fail++;
      $display("FAIL %s regs: got pc=%0d ir=%h retired=%0d required 0/0/0", name, a_pc, a_ir, a_ret);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_a_reset_values("reset");
    n_checks++;
    if ({b_busy, b_halted, b_ill, b_pc, b_ret} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_b: got busy/halted/ill/pc/ret=%b required 0", {b_busy, b_halted, b_ill, b_pc, b_ret});
    end
  endtask

  task automatic test_run_halt();
    do_reset();
    a_mem[0] = enc(OP_ADD, 0, 2, 1, 16'd4);
    a_mem[1] = enc(OP_HALT, 0, 0, 0, 0);
    a_run = 1;
    wait_stop(0, 60, "run_halt_wait");
    a_run = 0;
    n_checks++;
    if (a_exec_q.size() !== 1 || a_fetch_q.size() < 1 || a_exec_q[0] - a_fetch_q[0] !== 3) begin
      n_fail++;
      $display("FAIL run_halt_exec: got %0d strobes, required exactly one in cycle 4", a_exec_q.size());
    end
    n_checks++;
    if ({a_pc, a_ret, a_halted, a_ill} !== {8'd1, 16'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL run_halt_state: got pc=%0d ret=%0d halted=%b ill=%b required 1/2/1/0",
               a_pc, a_ret, a_halted, a_ill);
    end
  endtask

  task automatic test_step();
    logic [4:0] opf;
    do_reset();
    a_mem[0] = enc(OP_MOV, 5'd3, 0, 1, 16'd55);
    a_mem[1] = enc(OP_SUB, 5'd4, 5'd3, 0, 16'd2);
    a_step = 1; tick(); a_step = 0;
    wait_stop(0, 40, "step1_wait");
    opf = a_ir[31:27];
    n_checks++;
    if (a_exec_q.size() !== 1 || opf !== OP_MOV || a_pc !== 8'd1) begin
      n_fail++;
      $display("FAIL step1: got strobes=%0d op=%0d pc=%0d required 1/1/1", a_exec_q.size(), opf, a_pc);
    end
    n_checks++;
    if (a_busy !== 1'b0 || a_halted !== 1'b0 || a_ret !== 16'd1) begin
      n_fail++;
      $display("FAIL step1_idle: got busy=%b halted=%b ret=%0d required 0/0/1", a_busy, a_halted, a_ret);
    end
    repeat (4) tick();
    n_checks++;
    if (a_fetch_q.size() !== 1) begin
      n_fail++;
      $display("FAIL step1_stays_idle: got %0d fetches, required 1", a_fetch_q.size());
    end
    a_step = 1; tick(); a_step = 0;
    wait_stop(0, 40, "step2_wait");
    n_checks++;
    if (a_addr_q.size() !== 2 || a_addr_q[1] !== 1 || a_ir_q.size() !== 2 ||
        a_ir_q[1] !== a_mem[1] || a_pc !== 8'd2) begin
      n_fail++;
      $display("FAIL step2: got fetches=%0d pc=%0d ir=%h required 2/2/%h", a_addr_q.size(), a_pc, a_ir, a_mem[1]);
    end
  endtask

  task automatic test_mul_timing();
    do_reset();
    a_mem[0] = enc(OP_MUL, 1, 2, 0, 16'd3);
    a_mem[1] = enc(OP_ADD, 1, 1, 1, 16'd1);
    a_mem[2] = enc(OP_HALT, 0, 0, 0, 0);
    a_run = 1;
    wait_stop(0, 80, "mul_wait");
    a_run = 0;
    n_checks++;
    if (a_fetch_q.size() !== 3 || a_fetch_q[1] - a_fetch_q[0] !== 8 || a_fetch_q[2] - a_fetch_q[1] !== 5) begin
      n_fail++;
      $display("FAIL mul_timing: got %0d fetches, gaps %0d,%0d required 3 fetches gaps 8,5",
               a_fetch_q.size(), a_fetch_q[1] - a_fetch_q[0], a_fetch_q[2] - a_fetch_q[1]);
    end
    n_checks++;
    if (a_exec_q.size() !== 2 || a_ret !== 16'd3 || a_pc !== 8'd2) begin
      n_fail++;
      $display("FAIL mul_result: got strobes=%0d ret=%0d pc=%0d required 2/3/2", a_exec_q.size(), a_ret, a_pc);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    a_mem[0] = enc(OP_ADD, 1, 2, 1, 16'd7);
    a_mem[1] = enc(OP_ADD, 2, 1, 0, 16'd1);
    a_mem[2] = enc(5'b01010, 0, 0, 0, 0);
    a_run = 1;
    wait_stop(0, 80, "illegal_wait");
    a_run = 0;
    n_checks++;
    if ({a_ill, a_halted, a_ret, a_pc} !== {1'b1, 1'b1, 16'd2, 8'd2} || a_exec_q.size() !== 2) begin
      n_fail++;
      $display("FAIL illegal: got ill=%b halted=%b ret=%0d pc=%0d strobes=%0d required 1/1/2/2/2",
               a_ill, a_halted, a_ret, a_pc, a_exec_q.size());
    end
  endtask

  task automatic test_halt_req();
    do_reset();
    a_mem[0] = enc(OP_SUB, 1, 2, 0, 16'd3);
    a_mem[1] = enc(OP_ADD, 1, 1, 1, 16'd1);
    a_mem[2] = enc(OP_ADD, 1, 1, 1, 16'd1);
    a_run = 1;
    wait_exec(1, 40, "halt_req_exec");
    a_halt = 1;
    wait_stop(0, 40, "halt_req_wait");
    a_halt = 0;
    n_checks++;
    if ({a_halted, a_pc, a_ret} !== {1'b1, 8'd1, 16'd1} || a_exec_q.size() !== 1) begin
      n_fail++;
      $display("FAIL halt_req: got halted=%b pc=%0d ret=%0d strobes=%0d required 1/1/1/1",
               a_halted, a_pc, a_ret, a_exec_q.size());
    end
    a_step = 1; tick(); a_step = 0;
    repeat (15) tick();
    a_run = 0;
    n_checks++;
    if ({a_halted, a_busy, a_pc} !== {1'b1, 1'b0, 8'd1} || a_fetch_q.size() !== 1) begin
      n_fail++;
      $display("FAIL halted_sticky: got halted=%b busy=%b pc=%0d fetches=%0d required 1/0/1/1",
               a_halted, a_busy, a_pc, a_fetch_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) a_mem[i] = enc(OP_ADD, 5'(i), 1, 1, 16'(i));
    a_run = 1;
    wait_exec(2, 40, "b2b_exec");
    a_run = 0;
    wait_stop(0, 40, "b2b_wait");
    n_checks++;
    if (a_fetch_q.size() !== 2 || a_fetch_q[1] - a_fetch_q[0] !== 5) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d fetches gap %0d required 2 fetches gap 5",
               a_fetch_q.size(), a_fetch_q[1] - a_fetch_q[0]);
    end
    n_checks++;
    if ({a_pc, a_ret, a_halted, a_busy} !== {8'd2, 16'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_idle: got pc=%0d ret=%0d halted=%b busy=%b required 2/2/0/0",
               a_pc, a_ret, a_halted, a_busy);
    end
  endtask

  task automatic test_reset_mulwait();
    int n_exec;
    do_reset();
    a_mem[0] = enc(OP_MUL, 1, 2, 0, 16'd3);
    a_run = 1;
    wait_exec(1, 40, "rst_mul_exec");
    tick();
    #1 rst_n = 0;
    #1 check_a_reset_values("reset_mulwait");
    n_exec = a_exec_q.size();
    a_run = 0;
    repeat (4) tick();
    rst_n = 1;
    repeat (3) tick();
    n_checks++;
    if (a_exec_q.size() !== n_exec || n_exec !== 1 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mulwait_quiet: got strobes=%0d busy=%b required 1/0", a_exec_q.size(), a_busy);
    end
  endtask

  task automatic test_random();
    int len, gaps_bad, ir_bad;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) a_mem[i] = rnd_instr(5'($urandom_range(0, 4)));
      a_mem[len] = ($urandom_range(0, 1) == 0) ? rnd_instr(OP_HALT) : rnd_instr(5'($urandom_range(5, 30)));
      model_prog();
      a_run = 1;
      wait_stop(0, 150, "random_wait");
      a_run = 0;
      gaps_bad = 0;
      ir_bad = 0;
      if (a_fetch_q.size() != m_exec + 1 || a_ir_q.size() != m_exec) begin
        gaps_bad = 1;
      end else begin
        for (int i = 0; i < m_exec; i++) begin
          if (a_fetch_q[i+1] - a_fetch_q[i] != m_int_q[i]) gaps_bad++;
          if (a_ir_q[i] !== m_ir_q[i]) ir_bad++;
          if (a_exec_q[i] - a_fetch_q[i] != 3) gaps_bad++;
        end
      end
      n_checks++;
      if (gaps_bad != 0 || ir_bad != 0) begin
        n_fail++;
        $display("FAIL random%0d_trace: got %0d fetches, %0d bad gaps, %0d bad ir, required %0d fetches",
                 it, a_fetch_q.size(), gaps_bad, ir_bad, m_exec + 1);
      end
      n_checks++;
      if (int'(a_pc) != m_pc || int'(a_ret) != m_ret || a_ill !== m_ill || a_halted !== 1'b1) begin
        n_fail++;
        $display("FAIL random%0d_state: got pc=%0d ret=%0d ill=%b halted=%b required %0d/%0d/%b/1",
                 it, a_pc, a_ret, a_ill, a_halted, m_pc, m_ret, m_ill);
      end
    end
  endtask

  task automatic test_pc_wrap();
    int bad, n;
    do_reset();
    b_mem[2] = enc(OP_MUL, 1, 2, 0, 16'd3);
    b_run = 1;
    n = 0;
    while (b_fetch_q.size() < 5 && n < 60) begin tick(); n++; end
    b_run = 0;
    wait_stop(1, 40, "wrap_wait");
    bad = 0;
    if (b_addr_q.size() != 5) bad = 1;
    else for (int i = 0; i < 5; i++) if (b_addr_q[i] != (i % 4)) bad++;
    for (int i = 0; i + 1 < b_fetch_q.size(); i++) if (b_fetch_q[i+1] - b_fetch_q[i] != 5) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pc_wrap_seq: got %0d fetches with %0d errors, required pc 0,1,2,3,0 every 5 cycles",
               b_addr_q.size(), bad);
    end
    n_checks++;
    if ({b_pc, b_ret, b_halted, b_ill} !== {2'd1, 2'd3, 1'b0, 1'b0} || b_exec_q.size() !== 5 || b_ir !== b_mem[0]) begin
      n_fail++;
      $display("FAIL pc_wrap_end: got pc=%0d ret=%0d halted=%b ill=%b strobes=%0d required 1/3/0/0/5",
               b_pc, b_ret, b_halted, b_ill, b_exec_q.size());
    end
  endtask

  task automatic test_saturation();
    int exp_ret;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      b_step = 1; tick(); b_step = 0;
      wait_stop(1, 30, "sat_wait");
      exp_ret = (k > 3) ? 3 : k;
      n_checks++;
      if (int'(b_ret) != exp_ret || int'(b_pc) != (k % 4)) begin
        n_fail++;
        $display("FAIL saturation_step%0d: got ret=%0d pc=%0d required %0d/%0d", k, b_ret, b_pc, exp_ret, k % 4);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_halt();
    test_step();
    test_mul_timing();
    test_illegal();
    test_halt_req();
    test_back_to_back();
    test_reset_mulwait();
    test_random();
    test_pc_wrap();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
